// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, start/data/parity/stop FSM
// sampling mid-bit, and a one-entry valid/ready output buffer carrying the
// received word together with its parity and framing error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 50000000 / 115200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    input  logic              ready_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int H       = CLKS_PER_BIT / 2;
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int BW      = $clog2(BITS_N) + 1;
    localparam bit HAS_PAR = (PARITY_TYPE != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity error for a word plus its received parity bit.
    function automatic logic par_err_f(input logic [BITS_N-1:0] d, input logic p);
        logic ones_odd;
        ones_odd = (^d) ^ p;
        case (PARITY_TYPE)
            1:       return ~ones_odd;
            2:       return ones_odd;
            default: return 1'b0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_n_q, bit_n_d;
    logic [BITS_N-1:0] shreg_q, shreg_d;
    logic              par_bit_q, par_bit_d;
    logic              sync1_q, sync2_q;
    logic              rx_s;
    logic              commit_s;
    logic              stop_bad_s;
    logic [BITS_N:0]   sh_ext_s;

    logic [BITS_N-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    assign rx_s     = sync2_q;
    assign sh_ext_s = {rx_s, shreg_q};

    // Two-flop synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: next state, bit timing counter, shift register and commit strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_n_d    = bit_n_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        commit_s   = 1'b0;
        stop_bad_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                bit_n_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CW'(H - 1)) begin
                    cnt_d   = '0;
                    bit_n_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        // Start bit did not hold low to mid-bit: treat as glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shreg_d = sh_ext_s[BITS_N:1];
                    if (bit_n_q == BW'(BITS_N - 1)) begin
                        bit_n_d = '0;
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n_d = bit_n_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    cnt_d      = '0;
                    commit_s   = 1'b1;
                    stop_bad_s = ~rx_s;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                cnt_d   = '0;
                bit_n_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_n_q   <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_n_q   <= bit_n_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
        end
    end

    // Output buffer: accept/load/drop decision for a committed frame.
    always_comb begin
        data_d = data_q;
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovr_d  = 1'b0;
        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (commit_s) begin
            if (!valid_q || ready_in) begin
                data_d  = shreg_q;
                perr_d  = par_err_f(shreg_q, par_bit_q);
                ferr_d  = stop_bad_s;
                valid_d = 1'b1;
            end else begin
                // Old word still pending: keep it and flag the lost frame.
                ovr_d = 1'b1;
            end
        end else begin
            ovr_d = 1'b0;
        end
    end

    // Output holding registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_rx    = data_q;
    assign valid_out  = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no parity, odd, even) each on its own
// serial line, a queue scoreboard fed by the transmitter and drained by an
// output monitor, a table of frames, and hand sequences for corner cases.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        int          sel;
        logic [15:0] bits;
        int          nb;
        logic        stop;
        logic [7:0]  exp_d;
        logic        exp_pe;
        logic        exp_fe;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] line_s;
    logic [2:0] ready_s;
    logic [7:0] data_s [3];
    logic [2:0] valid_s, perr_s, ferr_s, ovr_s, busy_s;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cyc0 = 0;
    int   ovr_cnt0 = 0;
    logic vprev0 = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[10];

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0)) u_rx0 (
        .clk(clk), .rst(rst), .uart_in(line_s[0]), .ready_in(ready_s[0]),
        .data_rx(data_s[0]), .valid_out(valid_s[0]), .parity_err(perr_s[0]),
        .frame_err(ferr_s[0]), .overrun(ovr_s[0]), .busy(busy_s[0]));

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(1)) u_rx1 (
        .clk(clk), .rst(rst), .uart_in(line_s[1]), .ready_in(ready_s[1]),
        .data_rx(data_s[1]), .valid_out(valid_s[1]), .parity_err(perr_s[1]),
        .frame_err(ferr_s[1]), .overrun(ovr_s[1]), .busy(busy_s[1]));

    uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2)) u_rx2 (
        .clk(clk), .rst(rst), .uart_in(line_s[2]), .ready_in(ready_s[2]),
        .data_rx(data_s[2]), .valid_out(valid_s[2]), .parity_err(perr_s[2]),
        .frame_err(ferr_s[2]), .overrun(ovr_s[2]), .busy(busy_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one frame: start bit, nb bits LSB first, stop bit. Call at a negedge.
    task automatic send(input int sel, input logic [15:0] bits, input int nb, input logic stop);
        line_s[sel] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            line_s[sel] = bits[i];
            repeat (CPB) @(negedge clk);
        end
        line_s[sel] = stop;
        repeat (CPB) @(negedge clk);
        line_s[sel] = 1'b1;
    endtask

    // Output monitor: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (valid_s[i] && ready_s[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(i) + 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("word_dut", 32'(i), 32'(e.sel));
                        chk("word_data", {24'd0, data_s[i]}, {24'd0, e.d});
                        chk("word_perr", {31'd0, perr_s[i]}, {31'd0, e.pe});
                        chk("word_ferr", {31'd0, ferr_s[i]}, {31'd0, e.fe});
                    end
                end
            end
            if (valid_s[0] && !vprev0) rise_cyc0 = cyc;
            if (ovr_s[0]) ovr_cnt0++;
        end
        vprev0 = valid_s[0];
    end

    initial begin
        int m;
        int bad;
        exp_t e;

        vecs[0] = '{0, 16'h00A5, 8, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 16'h0055, 8, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[2] = '{0, 16'h0000, 8, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{0, 16'h00FF, 8, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1, 16'h0103, 9, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{1, 16'h0003, 9, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[6] = '{2, 16'h0107, 9, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{2, 16'h0007, 9, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[8] = '{1, 16'h0080, 9, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[9] = '{1, 16'h0103, 9, 1'b0, 8'h03, 1'b0, 1'b1};

        rst     = 1'b0;
        line_s  = 3'b111;
        ready_s = 3'b111;

        // Reset and idle.
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data_s[0]}, 32'd0);
        chk("rst_valid", {29'd0, valid_s}, 32'd0);
        chk("rst_flags", {26'd0, perr_s, ferr_s}, 32'd0);
        chk("rst_ovr_busy", {26'd0, ovr_s, busy_s}, 32'd0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((valid_s | perr_s | ferr_s | ovr_s | busy_s) != 3'b000) bad++;
            if ((data_s[0] | data_s[1] | data_s[2]) != 8'h00) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Basic frame with latency measurement.
        @(negedge clk);
        m = cyc;
        e = '{0, 8'hA5, 1'b0, 1'b0};
        exp_q.push_back(e);
        send(0, 16'h00A5, 8, 1'b1);
        repeat (4) @(negedge clk);
        chk("latency", 32'(rise_cyc0 - m), 32'(1 + 2 + H + 9 * CPB));
        chk("basic_pending", 32'(exp_q.size()), 32'd0);

        // Table of frames across the three parity modes.
        for (int v = 0; v < 10; v++) begin
            e = '{vecs[v].sel, vecs[v].exp_d, vecs[v].exp_pe, vecs[v].exp_fe};
            exp_q.push_back(e);
            @(negedge clk);
            send(vecs[v].sel, vecs[v].bits, vecs[v].nb, vecs[v].stop);
            repeat (4) @(negedge clk);
            chk("vec_pending", 32'(exp_q.size()), 32'd0);
        end

        // Glitch: 4-cycle low pulse must not start a frame.
        @(negedge clk);
        line_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        line_s[0] = 1'b1;
        @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy_s[0]}, 32'd1);
        repeat (6) @(negedge clk);
        chk("glitch_busy_low", {31'd0, busy_s[0]}, 32'd0);
        repeat (200) @(negedge clk);
        chk("glitch_no_word", {31'd0, valid_s[0]}, 32'd0);

        // Overrun: three back-to-back frames with ready low.
        ready_s[0] = 1'b0;
        ovr_cnt0 = 0;
        e = '{0, 8'h11, 1'b0, 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        send(0, 16'h0011, 8, 1'b1);
        send(0, 16'h0022, 8, 1'b1);
        send(0, 16'h0033, 8, 1'b1);
        repeat (4) @(negedge clk);
        chk("ovr_valid_held", {31'd0, valid_s[0]}, 32'd1);
        chk("ovr_data_held", {24'd0, data_s[0]}, 32'h11);
        chk("ovr_pulses", 32'(ovr_cnt0), 32'd2);
        ready_s[0] = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", {31'd0, valid_s[0]}, 32'd0);
        repeat (20) @(negedge clk);
        chk("ovr_valid_stays_low", {31'd0, valid_s[0]}, 32'd0);
        chk("ovr_pending", 32'(exp_q.size()), 32'd0);

        // Back-to-back with ready high: all three delivered in order.
        ovr_cnt0 = 0;
        e = '{0, 8'h11, 1'b0, 1'b0}; exp_q.push_back(e);
        e = '{0, 8'h22, 1'b0, 1'b0}; exp_q.push_back(e);
        e = '{0, 8'h33, 1'b0, 1'b0}; exp_q.push_back(e);
        @(negedge clk);
        send(0, 16'h0011, 8, 1'b1);
        send(0, 16'h0022, 8, 1'b1);
        send(0, 16'h0033, 8, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_pending", 32'(exp_q.size()), 32'd0);
        chk("b2b_no_ovr", 32'(ovr_cnt0), 32'd0);

        // Reset during data bit 4 of 0xFF, then a clean 0x3C.
        @(negedge clk);
        line_s[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        line_s[0] = 1'b1;
        repeat (4 * CPB + 8) @(negedge clk);
        chk("mid_busy_before", {31'd0, busy_s[0]}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid_s[0]}, 32'd0);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("mid_no_word", {31'd0, valid_s[0]}, 32'd0);
        e = '{0, 8'h3C, 1'b0, 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        send(0, 16'h003C, 8, 1'b1);
        repeat (4) @(negedge clk);
        chk("mid_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
